// File: rtl/hs_pkg.sv
// +----------------------------------------------------------------------+
// | hs_pkg : shared types and defaults for the SEND/ACK link arbiter     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package hs_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_ASSERT  = 3'd2,
      ST_RELEASE = 3'd3,
      ST_DONE    = 3'd4
   } hs_state_e;

   localparam int HS_DATA_W      = 32;
   localparam int HS_SYNC_STAGES = 2;

   // Index width for a requester number; never narrower than one bit.
   function automatic int hs_idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/hs_sync.sv
// +----------------------------------------------------------------------+
// | hs_sync : STAGES-flop level synchronizer, async active-high reset to 0|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module hs_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/handshake_arbiter.sv
// +----------------------------------------------------------------------+
// | handshake_arbiter : round-robin owner of a four-phase SEND/ACK link  |
// | Optional phase-timeout abort with err pulse when HS_TIMEOUT_EN set.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module handshake_arbiter
   import hs_pkg::*;
#(
   parameter int N_REQ          = 2,
   parameter int DATA_W         = HS_DATA_W,
   parameter int SYNC_STAGES    = HS_SYNC_STAGES,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] reqData,
   output logic [N_REQ-1:0]        done,
   output logic [N_REQ-1:0]        grant,
   input  logic                    ACK,
   output logic                    outSEND,
   output logic [DATA_W-1:0]       outDATA,
   output logic                    busy,
   output logic                    err
);

   localparam int IDX_W    = hs_idx_width(N_REQ);
   localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);

   if (N_REQ < 2 || N_REQ > 8 || SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("handshake_arbiter: unsupported parameter set");
   end

   hs_state_e             state_q, state_d;
   logic [IDX_W-1:0]      win_q, win_d;
   logic [IDX_W-1:0]      rr_q, rr_d;
   logic [N_REQ-1:0]      grant_q, grant_d;
   logic [N_REQ-1:0]      done_q, done_d;
   logic [DATA_W-1:0]     data_q, data_d;
   logic                  send_q, send_d;
   logic                  busy_q, busy_d;
   logic [SETTLE_W-1:0]   settle_q, settle_d;
   logic                  settled;
   logic                  ack_sync;
   logic                  phase_timeout;
   logic                  pick_valid;
   logic [IDX_W-1:0]      pick_idx;

   // Lowest set index at or after ptr, with wrap; scanned from the far end
   // so the nearest hit is the one left standing.
   function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [IDX_W-1:0] ptr);
      logic [IDX_W:0]   res;
      logic [IDX_W-1:0] sel;
      int               pos;
      res = '0;
      for (int off = N_REQ - 1; off >= 0; off--) begin
         pos = (int'(ptr) + off) % N_REQ;
         sel = IDX_W'(pos);
         if (r[sel]) res = {1'b1, sel};
      end
      return res;
   endfunction

   hs_sync #(
      .STAGES (SYNC_STAGES)
   ) u_ack_sync (
      .clk (clk),
      .rst (rst),
      .d_i (ACK),
      .q_o (ack_sync)
   );

   assign {pick_valid, pick_idx} = rr_pick(req, rr_q);

   // The synchronizer comes out of reset at 0 regardless of ACK; hold off
   // arbitration until it has had time to reflect a peripheral ACK still high.
   assign settled = (settle_q == SETTLE_W'(SYNC_STAGES));

   always_comb begin
      state_d  = state_q;
      win_d    = win_q;
      rr_d     = rr_q;
      grant_d  = grant_q;
      data_d   = data_q;
      settle_d = settled ? settle_q : settle_q + 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (pick_valid && !ack_sync && settled) begin
               state_d = ST_SETUP;
               win_d   = pick_idx;
               grant_d = N_REQ'(1) << pick_idx;
               data_d  = reqData[int'(pick_idx)*DATA_W +: DATA_W];
            end
         end
         ST_SETUP: begin
            state_d = ST_ASSERT;
         end
         ST_ASSERT: begin
            if (phase_timeout) begin
               state_d = ST_DONE;
            end else if (ack_sync) begin
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (phase_timeout || !ack_sync) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            grant_d = '0;
            rr_d    = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase

      send_d = (state_d == ST_ASSERT);
      done_d = (state_d == ST_DONE) ? grant_q : '0;
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         win_q    <= '0;
         rr_q     <= '0;
         grant_q  <= '0;
         done_q   <= '0;
         data_q   <= '0;
         send_q   <= 1'b0;
         busy_q   <= 1'b0;
         settle_q <= '0;
      end else begin
         state_q  <= state_d;
         win_q    <= win_d;
         rr_q     <= rr_d;
         grant_q  <= grant_d;
         done_q   <= done_d;
         data_q   <= data_d;
         send_q   <= send_d;
         busy_q   <= busy_d;
         settle_q <= settle_d;
      end
   end

`ifdef HS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q;

   // Counter restarts on every state change, so it is zero on entry to
   // ASSERT and to RELEASE and only runs while a phase is pending.
   always_comb begin
      cnt_d = '0;
      if ((state_q == ST_ASSERT || state_q == ST_RELEASE) && state_d == state_q) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign phase_timeout = (state_q == ST_ASSERT || state_q == ST_RELEASE) &&
                          (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= phase_timeout;
      end
   end

   assign err = err_q;
`else
   assign phase_timeout = 1'b0;
   assign err           = 1'b0;
`endif

   assign done    = done_q;
   assign grant   = grant_q;
   assign outSEND = send_q;
   assign outDATA = data_q;
   assign busy    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_handshake_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_handshake_arbiter : directed self-checking bench, 10 ns / 14 ns   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_handshake_arbiter;

   localparam int N  = 2;
   localparam int DW = 32;
   localparam int SS = 2;
`ifdef HS_TIMEOUT_EN
   localparam int TB_TO = 10;
`else
   localparam int TB_TO = 255;
`endif

   logic            clk = 1'b0;
   logic            pclk = 1'b0;
   logic            rst = 1'b1;
   logic            ACK = 1'b0;
   logic [N-1:0]    req = '0;
   logic [N*DW-1:0] reqData = '0;
   logic [N-1:0]    done, grant;
   logic            outSEND, busy, err;
   logic [DW-1:0]   outDATA;

   int n_checks = 0;
   int n_errors = 0;

   // peripheral model controls
   int   ack_dly  = 3;
   int   ack_hold = 0;
   bit   per_off  = 1'b0;
   bit   rand_dly = 1'b0;
   int   cur_dly  = 0;
   int   dcnt     = 0;
   int   hcnt     = 0;
   bit   err_seen = 1'b0;
   logic [DW-1:0] rx[$];
   logic [DW-1:0] expq[$];

   handshake_arbiter #(
      .N_REQ          (N),
      .DATA_W         (DW),
      .SYNC_STAGES    (SS),
      .TIMEOUT_CYCLES (TB_TO)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .reqData (reqData),
      .done    (done),
      .grant   (grant),
      .ACK     (ACK),
      .outSEND (outSEND),
      .outDATA (outDATA),
      .busy    (busy),
      .err     (err)
   );

   always #5 clk = ~clk;
   always #7 pclk = ~pclk;

   // Peripheral: raise ACK some pclk cycles after SEND, capture the word,
   // drop ACK some pclk cycles after SEND falls.
   always @(posedge pclk) begin
      if (per_off) begin
         ACK  <= 1'b0;
         dcnt <= 0;
      end else if (outSEND && !ACK) begin
         if (dcnt >= (rand_dly ? cur_dly : ack_dly)) begin
            ACK  <= 1'b1;
            dcnt <= 0;
            rx.push_back(outDATA);
            cur_dly <= $urandom_range(0, 2);
         end else begin
            dcnt <= dcnt + 1;
         end
      end else if (!outSEND && ACK) begin
         if (hcnt >= ack_hold) begin
            ACK  <= 1'b0;
            hcnt <= 0;
         end else begin
            hcnt <= hcnt + 1;
         end
      end
   end

   always @(negedge clk) if (err) err_seen <= 1'b1;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(output logic [N-1:0] d);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (done == '0 && k < 80);
      if (done == '0) check_val("wait_done_bound", {63'd0, done != '0}, 64'd1);
      d = done;
   endtask

   task automatic wait_grant();
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (grant == '0 && k < 80);
      if (grant == '0) check_val("wait_grant_bound", {63'd0, grant != '0}, 64'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   localparam logic [DW-1:0] WA = 32'h1111_AAAA;
   localparam logic [DW-1:0] WB = 32'h2222_BBBB;

   initial begin
      logic [N-1:0]  d;
      logic [N-1:0]  pending;
      logic [N-1:0]  exp_oh;
      logic [DW-1:0] words [N];
      int            gap, viol, k, hi, ptr, w, total;

      // reset state
      repeat (2) @(negedge clk);
      check_val("rst_outSEND", outSEND, 0);
      check_val("rst_outDATA", outDATA, 0);
      check_val("rst_done", done, 0);
      check_val("rst_grant", grant, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_err", err, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // single request
      reqData[0 +: DW] = 32'hDEAD_BEEF;
      req = 2'b01;
      rx.delete();
      wait_grant();
      check_val("single_grant", grant, 2'b01);
      check_val("single_data_setup", outDATA, 32'hDEAD_BEEF);
      check_val("single_send_low_in_setup", outSEND, 0);
      @(negedge clk);
      check_val("single_send_rise", outSEND, 1);
      wait_done(d);
      check_val("single_done", d, 2'b01);
      check_val("single_err", err, 0);
      req = 2'b00;
      @(negedge clk);
      check_val("single_done_one_cycle", done, 0);
      check_val("single_busy_after", busy, 0);
      check_val("single_rx_count", rx.size(), 1);
      if (rx.size() > 0) check_val("single_rx_word", rx[0], 32'hDEAD_BEEF);

      // simultaneous requests from rrPtr=0
      do_reset();
      rx.delete();
      reqData = {WB, WA};
      req = 2'b11;
      wait_done(d);
      check_val("simul_first", d, 2'b01);
      req[0] = 1'b0;
      wait_done(d);
      check_val("simul_second", d, 2'b10);
      req = 2'b00;
      check_val("simul_rx_count", rx.size(), 2);
      if (rx.size() == 2) begin
         check_val("simul_rx0", rx[0], WA);
         check_val("simul_rx1", rx[1], WB);
      end
      repeat (3) @(negedge clk);

      // fairness with both held for four transfers
      rx.delete();
      req = 2'b11;
      for (int t = 0; t < 4; t++) begin
         wait_done(d);
         check_val("fair_order", d, (t % 2 == 0) ? 2'b01 : 2'b10);
         if (t == 3) begin
            req = 2'b00;
         end else if (t == 0) begin
            gap = 0;
            do begin
               @(negedge clk);
               gap++;
            end while (grant == '0 && gap < 20);
            check_val("b2b_gap", gap, 2);
         end
      end
      check_val("fair_rx_count", rx.size(), 4);
      if (rx.size() == 4) begin
         for (int i = 0; i < 4; i++) check_val("fair_rx_word", rx[i], (i % 2 == 0) ? WA : WB);
      end
      repeat (3) @(negedge clk);

      // reset during RELEASE while peripheral still holds ACK
      ack_hold = 6;
      req = 2'b01;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(ACK && !outSEND && busy && done == '0 && grant != '0) && k < 80);
      check_val("rst_mid_found_release", {63'd0, ACK && busy}, 1);
      rst = 1'b1;
      #1;
      check_val("rst_mid_send", outSEND, 0);
      check_val("rst_mid_grant", grant, 0);
      check_val("rst_mid_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      viol = 0;
      k = 0;
      while (ACK && k < 200) begin
         @(negedge clk);
         k++;
         if (outSEND || grant != '0 || done != '0) viol++;
      end
      check_val("rst_mid_blocked_while_ack", viol, 0);
      gap = 0;
      do begin
         @(negedge clk);
         gap++;
      end while (grant == '0 && gap < 40);
      check_val("rst_mid_sync_wait", {63'd0, gap >= SS && gap < 40}, 1);
      wait_done(d);
      check_val("rst_mid_fresh_done", d, 2'b01);
      req = 2'b00;
      ack_hold = 0;
      repeat (12) @(negedge clk);

`ifdef HS_TIMEOUT_EN
      // peripheral silent: phase timeout
      per_off = 1'b1;
      req = 2'b01;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!outSEND && k < 40);
      hi = 0;
      while (outSEND && hi < 50) begin
         hi++;
         @(negedge clk);
      end
      check_val("to_send_high_cycles", hi, TB_TO);
      check_val("to_done", done, 2'b01);
      check_val("to_err", err, 1);
      req = 2'b00;
      @(negedge clk);
      check_val("to_err_one_cycle", err, 0);
      check_val("to_idle", busy, 0);
      per_off = 1'b0;
      repeat (4) @(negedge clk);
`endif

      // random transfers across the two clock domains
      do_reset();
      rx.delete();
      expq.delete();
      rand_dly = 1'b1;
      ptr = 0;
      total = 0;
      while (total < 20) begin
         pending = N'($urandom_range(1, 3));
         for (int i = 0; i < N; i++) begin
            words[i] = $urandom;
            reqData[i*DW +: DW] = words[i];
         end
         req = pending;
         while (pending != '0 && total < 40) begin
            w = -1;
            for (int off = N - 1; off >= 0; off--) begin
               if (pending[(ptr + off) % N]) w = (ptr + off) % N;
            end
            exp_oh = N'(1) << w;
            wait_done(d);
            check_val("mix_winner", d, exp_oh);
            expq.push_back(words[w]);
            req = req & ~exp_oh;
            pending = pending & ~exp_oh;
            ptr = (w + 1) % N;
            total++;
         end
      end
      repeat (12) @(negedge clk);
      check_val("mix_rx_count", rx.size(), expq.size());
      for (int i = 0; i < expq.size(); i++) begin
         if (i < rx.size()) check_val("mix_rx_word", rx[i], expq[i]);
      end

`ifndef HS_TIMEOUT_EN
      check_val("err_never_pulsed", err_seen, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1);
   end

endmodule

`default_nettype wire
